huffman_decode: RTL and testbench
=================================

# huffman_decode

Downstream counterpart of the Huffman packer. Pops 32-bit packed words from a first-word-fall-through FIFO, unpacks the MSB-first variable-length code stream and pushes one 4-bit fixed-length symbol per cycle into an output FIFO. End-of-stream (EOS) codes are decoded, flagged, and the zero padding behind them is discarded, so back-to-back messages decode cleanly.

## Interface
- p_width, 32, packed word width; only 32 is supported.
- c_width, 4, fixed-length symbol width.
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- idata  input  p_width  packed word at the input FIFO head; first stream bit is idata[31]; valid while rdy=1.
- rdy  input  1  input FIFO not empty.
- pop  output  1  registered; pops the input FIFO; idata is captured in the same cycle pop=1.
- code  output  c_width  registered decoded symbol; valid when push=1.
- eom  output  1  registered; high with push when code=8 (EOS).
- push  output  1  registered; writes code/eom into the output FIFO.
- not_full  input  1  output FIFO can accept a push this cycle.

## Operation
- Code table (stream order, first bit leftmost) -> symbol: 00->4 (E), 01->7 (H), 100->0 (A), 101->3 (D), 1100->2 (C), 1101->5 (F), 1110->6 (G), 11110->1 (B), 11111->8 (EOS). Complete prefix code, so no invalid pattern exists.
- State: 64-bit bit buffer buf, MSB-aligned (oldest bit at buf[63]); 7-bit count cnt (0..64); pop register.
- Fetch: if rdy=1, pop=0, and cnt<=32 in cycle t, then pop=1 in cycle t+1. Never pop on two consecutive cycles.
- Capture: in a cycle with pop=1, idata is written at buf[63-c -: 32], where c is cnt after this cycle's decode. cnt increases by 32.
- Decode: L is the length of the code in buf[63:59]. A decode fires when L<=cnt and not_full=1. At the clock edge: code<=symbol, push<=1, eom<=(symbol==8), buf shifts left by L, cnt-=L.
- Decode and capture can occur in the same cycle. At most one symbol is decoded per cycle.
- EOS discard: when the decoded symbol is 8, the shift and decrement total 5+r bits, where r=(cnt-5)[4:0]. This drops the remainder of the word that holds the EOS end. A following full word already in buf, or a capture in flight, is kept.
- Stall: with not_full=0, no decode fires, buf is held, push=0, and fetch continues while cnt<=32.
- Reset: buf=0, cnt=0, pop=0, push=0, eom=0, code=0. Any in-flight pop is aborted; the FIFO word is not consumed because pop is low after reset.

## Timing
- All outputs are registered. Every output is 0 in the cycle after reset is sampled.
- Empty start, rdy rises in cycle 0: pop=1 in cycle 1 and buf is loaded at the end of cycle 1. The first decode happens in cycle 2, with push=1 in cycle 3.
- Sustained throughput is one symbol per cycle while not_full=1 and rdy keeps cnt supplied. Input bandwidth is 32 bits per 2 cycles, which is at least the 10-bit worst-case demand.
- push is a one-cycle pulse per symbol. Consecutive symbols give consecutive push cycles.
- cnt never exceeds 64: the fetch check (cnt<=32 at t) plus the non-increasing count in t+1 bound it.
- rdy must stay 1 from the fetch decision through the pop cycle. This holds because only this block drains the FIFO.

## Test plan
- Single word 0x87C00000 (A,E,EOS), not_full=1 -> pop in cycle 1; pushes in cycles 3,4,5 with code 0,4,8; eom=1 only with 8; cnt=0 afterward; no further pushes.
- Words 0x00000003 then 0xDF000000 (15×E, B split across the word boundary, EOS) -> 15 pushes of 4, then 1, then 8+eom; exactly 17 pushes.
- Words 0x87C00000 then 0x7F000000 queued together -> 0,4,8,7,8 with eom on both 8s; no E decoded from padding.
- Word 0x0000099F (10×E, A, C, EOS ending exactly at bit 0) then 0x7F000000 -> 10×4, 0, 2, 8, 7, 8; zero bits discarded after the first EOS.
- Stream of 16 words of random symbols with not_full toggled randomly, including a 10-cycle hold -> push never high while not_full=0 is sampled; symbol sequence matches the model; no loss or duplication.
- reset asserted for 1 cycle after the 3rd push of a 2-word stream -> all outputs 0 next cycle; a fresh 0x87C00000 then decodes as 0,4,8 with standard latency.

Source files
------------

// File: rtl/huffman_decode.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decode
// Purpose  : Unpacks an MSB-first variable-length Huffman code stream arriving
//            as 32-bit words from a first-word-fall-through FIFO and emits one
//            4-bit fixed-length symbol per cycle into an output FIFO. EOS codes
//            are flagged on eom and the zero padding behind them is dropped.
// Ports    : clk      - clock, all state on rising edge
//            reset    - synchronous active-high reset
//            idata    - packed word at input FIFO head (first bit at MSB)
//            rdy      - input FIFO not empty
//            pop      - registered pop strobe; idata captured while high
//            code     - registered decoded symbol, valid with push
//            eom      - registered end-of-message flag (code == 8)
//            push     - registered write strobe for the output FIFO
//            not_full - output FIFO can accept a push this cycle
// Revision : 1.0 - initial release
// ============================================================================
module huffman_decode #(
    parameter int P_WIDTH = 32,
    parameter int C_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P_WIDTH-1:0] idata,
    input  logic               rdy,
    output logic               pop,
    output logic [C_WIDTH-1:0] code,
    output logic               eom,
    output logic               push,
    input  logic               not_full
);

    localparam int c_BUF_W = 2 * P_WIDTH;
    localparam int c_CNT_W = $clog2(c_BUF_W + 1);

    // Bit buffer is MSB-aligned: oldest unconsumed bit sits at r_buf[MSB].
    // Bits below the valid count are always zero, which lets a capture be
    // merged with a simple OR.
    logic [c_BUF_W-1:0] r_buf;
    logic [c_CNT_W-1:0] r_cnt;

    logic [4:0]         w_head;
    logic [c_CNT_W-1:0] w_len;
    logic [C_WIDTH-1:0] w_sym;
    logic               w_fire;
    logic               w_eos;
    logic [c_CNT_W-1:0] w_skip;
    logic [c_CNT_W-1:0] w_shift;
    logic [c_CNT_W-1:0] w_cnt_dec;
    logic [c_BUF_W-1:0] w_buf_sh;
    logic [c_BUF_W-1:0] w_ins;
    logic               w_pop_next;

    assign w_head = r_buf[c_BUF_W-1 -: 5];

    // Prefix-code lookup on the five oldest bits.
    always_comb begin
        w_len = c_CNT_W'(2);
        w_sym = C_WIDTH'(4);
        casez (w_head)
            5'b00???: begin w_len = c_CNT_W'(2); w_sym = C_WIDTH'(4); end
            5'b01???: begin w_len = c_CNT_W'(2); w_sym = C_WIDTH'(7); end
            5'b100??: begin w_len = c_CNT_W'(3); w_sym = C_WIDTH'(0); end
            5'b101??: begin w_len = c_CNT_W'(3); w_sym = C_WIDTH'(3); end
            5'b1100?: begin w_len = c_CNT_W'(4); w_sym = C_WIDTH'(2); end
            5'b1101?: begin w_len = c_CNT_W'(4); w_sym = C_WIDTH'(5); end
            5'b1110?: begin w_len = c_CNT_W'(4); w_sym = C_WIDTH'(6); end
            5'b11110: begin w_len = c_CNT_W'(5); w_sym = C_WIDTH'(1); end
            default:  begin w_len = c_CNT_W'(5); w_sym = C_WIDTH'(8); end
        endcase
    end

    assign w_fire = not_full && (w_len <= r_cnt);
    assign w_eos  = (w_sym == C_WIDTH'(8));

    // On EOS, the bits still held from the word containing the EOS end are
    // (cnt-5) mod 32; consuming them as well realigns the buffer on the next
    // word boundary while keeping any later full word intact.
    assign w_skip = c_CNT_W'(5) + ((r_cnt - c_CNT_W'(5)) & c_CNT_W'(P_WIDTH - 1));

    assign w_shift   = !w_fire ? '0 : (w_eos ? w_skip : w_len);
    assign w_cnt_dec = r_cnt - w_shift;
    assign w_buf_sh  = r_buf << w_shift;
    // New word lands directly behind the bits that survive this cycle's decode.
    assign w_ins     = {idata, {P_WIDTH{1'b0}}} >> w_cnt_dec;

    // Fetch only with room for a full word; never on back-to-back cycles so
    // the FIFO head is always stable when captured.
    assign w_pop_next = rdy && !pop && (r_cnt <= c_CNT_W'(P_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
            r_cnt <= '0;
            pop   <= 1'b0;
            push  <= 1'b0;
            eom   <= 1'b0;
            code  <= '0;
        end else begin
            pop  <= w_pop_next;
            push <= w_fire;
            eom  <= w_fire && w_eos;
            if (w_fire) begin
                code <= w_sym;
            end
            if (pop) begin
                r_buf <= w_buf_sh | w_ins;
                r_cnt <= w_cnt_dec + c_CNT_W'(P_WIDTH);
            end else begin
                r_buf <= w_buf_sh;
                r_cnt <= w_cnt_dec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_decode
// Purpose  : Self-checking bench for huffman_decode. A bit-serial reference
//            decoder fills an expected-symbol queue as words are queued into
//            a modelled input FIFO; every DUT push is popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] idata = 32'h0;
    logic        rdy = 1'b0;
    logic        pop;
    logic [3:0]  code;
    logic        eom;
    logic        push;
    logic        not_full = 1'b1;

    huffman_decode dut (
        .clk      (clk),
        .reset    (reset),
        .idata    (idata),
        .rdy      (rdy),
        .pop      (pop),
        .code     (code),
        .eom      (eom),
        .push     (push),
        .not_full (not_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] in_q[$];
    int          exp_q[$];
    bit          mq[$];
    int          pop_log[$];
    int          push_log[$];
    int          npush = 0;
    bit          sb_off = 1'b0;
    bit          nf_rand = 1'b0;
    int          hold = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_pop = 1'b0;
    logic        nf_prev = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: walks the stream bit by bit; after EOS it drops the
    // rest of the current 32-bit word.
    task automatic model_add(input logic [31:0] w);
        int len;
        int sym;
        for (int i = 31; i >= 0; i--) mq.push_back(w[i]);
        while (1) begin
            len = 0;
            sym = 0;
            if (mq.size() >= 2 && !mq[0]) begin
                len = 2; sym = mq[1] ? 7 : 4;
            end else if (mq.size() >= 3 && mq[0] && !mq[1]) begin
                len = 3; sym = mq[2] ? 3 : 0;
            end else if (mq.size() >= 4 && mq[0] && mq[1] && !mq[2]) begin
                len = 4; sym = mq[3] ? 5 : 2;
            end else if (mq.size() >= 4 && mq[0] && mq[1] && mq[2] && !mq[3]) begin
                len = 4; sym = 6;
            end else if (mq.size() >= 5 && mq[0] && mq[1] && mq[2] && mq[3]) begin
                len = 5; sym = mq[4] ? 8 : 1;
            end
            if (len == 0) break;
            repeat (len) void'(mq.pop_front());
            exp_q.push_back(sym);
            if (sym == 8) repeat (mq.size() % 32) void'(mq.pop_front());
        end
    endtask

    function automatic void enc(input int s, output logic [4:0] c, output int l);
        case (s)
            0:       begin c = 5'b00100; l = 3; end
            1:       begin c = 5'b11110; l = 5; end
            2:       begin c = 5'b01100; l = 4; end
            3:       begin c = 5'b00101; l = 3; end
            4:       begin c = 5'b00000; l = 2; end
            5:       begin c = 5'b01101; l = 4; end
            6:       begin c = 5'b01110; l = 4; end
            7:       begin c = 5'b00001; l = 2; end
            default: begin c = 5'b11111; l = 5; end
        endcase
    endfunction

    task automatic send(input logic [31:0] w);
        in_q.push_back(w);
        model_add(w);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        check_eq({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Idle decoder assumed; checks fetch and push latency of 0x87C00000.
    task automatic latency_run(input string tag);
        int t0;
        pop_log.delete();
        push_log.delete();
        npush = 0;
        @(negedge clk);
        t0 = cyc + 1;
        send(32'h87C00000);
        drain(tag, 50);
        check_eq({tag, "_npush"}, npush, 3);
        check_eq({tag, "_npop"}, pop_log.size(), 1);
        check_eq({tag, "_pop_cyc"}, (pop_log.size() > 0) ? pop_log[0] - t0 : -1, 1);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("%s_push%0d_cyc", tag, i),
                     (push_log.size() > i) ? push_log[i] - t0 : -1, 3 + i);
    endtask

    // Input FIFO model and not_full driver.
    initial begin
        bit ps;
        forever begin
            @(negedge clk);
            ps = pop;
            @(posedge clk);
            #1;
            if (ps && in_q.size() > 0) void'(in_q.pop_front());
            rdy   = (in_q.size() > 0);
            idata = rdy ? in_q[0] : 32'h0;
            if (hold > 0) begin
                not_full = 1'b0;
                hold--;
            end else if (nf_rand) begin
                not_full = ($urandom_range(0, 2) != 0);
            end else begin
                not_full = 1'b1;
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        int e;
        if (pop) begin
            check_eq("pop_b2b", prev_pop, 1'b0);
            pop_log.push_back(cyc);
        end
        prev_pop = pop;
        if (push && !sb_off && !reset) begin
            npush++;
            push_log.push_back(cyc);
            check_eq("push_while_full", nf_prev, 1'b1);
            if (exp_q.size() == 0) begin
                check_eq("extra_push", code, 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check_eq("code", code, e);
                check_eq("eom", eom, (e == 8));
            end
        end
        nf_prev = not_full;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit          sq[$];
        logic [4:0]  c;
        int          l;
        int          nsym;
        logic [31:0] w;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_pop", pop, 0);
        check_eq("rst_push", push, 0);
        check_eq("rst_eom", eom, 0);
        check_eq("rst_code", code, 0);
        reset = 1'b0;

        // A,E,EOS with exact latency
        latency_run("t1");

        // 15xE, B across boundary, EOS
        npush = 0;
        @(negedge clk);
        send(32'h00000003);
        send(32'hDF000000);
        drain("t2", 200);
        check_eq("t2_npush", npush, 17);

        // two messages queued together
        npush = 0;
        send(32'h87C00000);
        send(32'h7F000000);
        drain("t3", 200);
        check_eq("t3_npush", npush, 5);

        // EOS ending exactly on the word boundary
        npush = 0;
        send(32'h0000099F);
        send(32'h7F000000);
        drain("t4", 200);
        check_eq("t4_npush", npush, 15);

        // random symbols, random backpressure plus a 10-cycle hold
        nsym = 0;
        while (sq.size() + 10 <= 512) begin
            enc($urandom_range(0, 7), c, l);
            for (int j = l - 1; j >= 0; j--) sq.push_back(c[j]);
            nsym++;
        end
        enc(8, c, l);
        for (int j = l - 1; j >= 0; j--) sq.push_back(c[j]);
        nsym++;
        while (sq.size() < 512) sq.push_back(1'b0);
        npush = 0;
        nf_rand = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 32; b++) w[31-b] = sq[k*32 + b];
            send(w);
        end
        repeat (20) @(negedge clk);
        hold = 10;
        drain("t5", 3000);
        nf_rand = 1'b0;
        check_eq("t5_npush", npush, nsym);

        // reset mid-stream
        npush = 0;
        send(32'h87C00000);
        send(32'h7F000000);
        for (int k = 0; k < 100 && npush < 3; k++) @(negedge clk);
        check_eq("t6_reach3", (npush >= 3), 1);
        sb_off = 1'b1;
        reset  = 1'b1;
        in_q.delete();
        exp_q.delete();
        mq.delete();
        @(negedge clk);
        check_eq("t6_rst_pop", pop, 0);
        check_eq("t6_rst_push", push, 0);
        check_eq("t6_rst_eom", eom, 0);
        check_eq("t6_rst_code", code, 0);
        reset  = 1'b0;
        sb_off = 1'b0;
        latency_run("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
